dmem_ws: RTL and testbench

Parametrised data memory with wait states, byte/halfword/word access and a ready/err handshake. It replaces the single-cycle data memory behind the CPU's `maddr`/`wdata`/`rdata` path. It adds:
- programmable access latency;
- sub-word loads and stores with sign or zero extension;
- alignment and range checking.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane.sv | 51 +++++
 rtl/dmem_ws.sv | 156 +++++++++++++++
 tb/tb_dmem_ws.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, state encoding and alignment helper for the wait-state data memory.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // A half must sit on an even byte, a word on a multiple of four.
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane datapath: load extraction/extension and store merge for one 32-bit word.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  a,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_byte = word[8*a +: 8];
   assign ld_half = a[1] ? word[31:16] : word[15:0];

   // Select the addressed lanes and extend to 32 bits.
   always_comb begin
      ld_data = word;
      case (size)
         SZ_B:    ld_data = sign ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
         SZ_H:    ld_data = sign ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
         default: ld_data = word;
      endcase
   end

   // Each lane is replaced only when the access covers it; the right-aligned
   // store data is routed to the lane position it belongs to.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       be;
         logic [7:0] src;

         assign be = ((size == SZ_B) && (a == LANE)) ||
                     ((size == SZ_H) && (a[1] == LANE[1])) ||
                     (size == SZ_W);

         assign src = (size == SZ_B) ? wdata[7:0] :
                      (size == SZ_H) ? wdata[8*(gi%2) +: 8] :
                                       wdata[8*gi +: 8];

         assign st_data[8*gi +: 8] = be ? src : word[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/dmem_ws.sv
// Data memory with programmable wait states, sub-word access and ready/err handshake.
module dmem_ws
   import dmem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int WAIT  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        dm_r,
   input  logic        dm_w,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
);

   localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_C = 4'(WAIT);

   state_t        state_reg, state_next;
   logic [3:0]    cnt_reg, cnt_next;
   logic          op_w_reg, op_w_next;
   logic [AW+1:0] addr_reg, addr_next;
   logic [31:0]   wdata_reg, wdata_next;
   logic [1:0]    size_reg, size_next;
   logic          sign_reg, sign_next;
   logic [31:0]   rdata_reg, rdata_next;
   logic          err_reg, err_next;

   logic [31:0]   mem [DEPTH];
   logic [31:0]   mem_q;
   logic          mem_rd;
   logic          mem_we;

   logic          req;
   logic          req_err;
   logic [31:0]   ld_data;
   logic [31:0]   st_data;

   assign req     = cs && (dm_r || dm_w);
   assign req_err = (dm_r && dm_w) ||
                    (size == 2'd3) ||
                    misaligned(size, addr[1:0]) ||
                    ({2'b00, addr[31:2]} >= 32'(DEPTH));

   dmem_lane u_lane (
      .word    (mem_q),
      .wdata   (wdata_reg),
      .a       (addr_reg[1:0]),
      .size    (size_reg),
      .sign    (sign_reg),
      .ld_data (ld_data),
      .st_data (st_data)
   );

   // Control and response registers; reset takes effect immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         op_w_reg  <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= 32'h0;
         size_reg  <= SZ_B;
         sign_reg  <= 1'b0;
         rdata_reg <= 32'h0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         op_w_reg  <= op_w_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         size_reg  <= size_next;
         sign_reg  <= sign_next;
         rdata_reg <= rdata_next;
         err_reg   <= err_next;
      end
   end

   // Next-state logic: accept in IDLE, count down in BUSY, pulse ready in RESP.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      op_w_next  = op_w_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      size_next  = size_reg;
      sign_next  = sign_reg;
      rdata_next = rdata_reg;
      err_next   = err_reg;
      mem_rd     = 1'b0;
      mem_we     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req) begin
               op_w_next  = dm_w;
               addr_next  = addr[AW+1:0];
               wdata_next = wdata;
               size_next  = size;
               sign_next  = sign;
               if (req_err) begin
                  err_next   = 1'b1;
                  rdata_next = 32'h0;
                  state_next = RESP;
               end else begin
                  err_next   = 1'b0;
                  cnt_next   = WAIT_C;
                  mem_rd     = 1'b1;
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               state_next = RESP;
               if (op_w_reg) begin
                  mem_we     = 1'b1;
                  rdata_next = 32'h0;
               end else begin
                  rdata_next = ld_data;
               end
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Word storage: the old word is fetched at acceptance so the store merge
   // and the load extraction both work from a registered read.
   always_ff @(posedge clk) begin
      if (mem_rd) begin
         mem_q <= mem[addr[AW+1:2]];
      end
      if (mem_we) begin
         mem[addr_reg[AW+1:2]] <= st_data;
      end
   end

   assign rdata = rdata_reg;
   assign ready = (state_reg == RESP);
   assign err   = ready && err_reg;

endmodule

// File: tb/tb_dmem_ws.sv
// Directed bench for dmem_ws: several instances cover the wait-state sweep.
module tb_dmem_ws;

   localparam int NI = 5;
   localparam int WAITS [NI] = '{1, 0, 3, 15, 4};

   logic        clk = 1'b0;
   logic        rst_a   [NI];
   logic        cs_a    [NI];
   logic        dm_r_a  [NI];
   logic        dm_w_a  [NI];
   logic [1:0]  size_a  [NI];
   logic        sign_a  [NI];
   logic [31:0] addr_a  [NI];
   logic [31:0] wdata_a [NI];
   logic [31:0] rdata_a [NI];
   logic        ready_a [NI];
   logic        err_a   [NI];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         dmem_ws #(.DEPTH(64), .WAIT(WAITS[gi])) u_dut (
            .clk   (clk),
            .rst   (rst_a[gi]),
            .cs    (cs_a[gi]),
            .dm_r  (dm_r_a[gi]),
            .dm_w  (dm_w_a[gi]),
            .size  (size_a[gi]),
            .sign  (sign_a[gi]),
            .addr  (addr_a[gi]),
            .wdata (wdata_a[gi]),
            .rdata (rdata_a[gi]),
            .ready (ready_a[gi]),
            .err   (err_a[gi])
         );
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Issue one request at cycle 0 and measure the cycle in which ready appears.
   task automatic access(input int k, input logic r, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d,
                         input logic hold, output int lat, output logic [31:0] rd,
                         output logic e);
      int cyc;
      cs_a[k] = 1'b1; dm_r_a[k] = r; dm_w_a[k] = w;
      size_a[k] = sz; sign_a[k] = sg; addr_a[k] = a; wdata_a[k] = d;
      @(posedge clk); #1;
      cyc = 1;
      if (!hold) cs_a[k] = 1'b0;
      while (!ready_a[k] && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      lat = ready_a[k] ? cyc : 99;
      rd  = rdata_a[k];
      e   = err_a[k];
      cs_a[k] = 1'b0; dm_r_a[k] = 1'b0; dm_w_a[k] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic op(input string tag, input int k, input logic r, input logic w,
                     input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [31:0] d, input logic hold, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_err);
      int          lat;
      logic [31:0] rd;
      logic        e;
      access(k, r, w, sz, sg, a, d, hold, lat, rd, e);
      $display("txn %-10s inst=%0d r=%0b w=%0b sz=%0d sg=%0b a=0x%08h d=0x%08h lat=%0d rdata=0x%08h err=%0b",
               tag, k, r, w, sz, sg, a, d, lat, rd, e);
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".rdata"}, rd, exp_rd);
      check({tag, ".err"}, {31'h0, e}, {31'h0, exp_err});
   endtask

   initial begin
      int pulses;
      for (int i = 0; i < NI; i++) begin
         rst_a[i] = 1'b0; cs_a[i] = 1'b0; dm_r_a[i] = 1'b0; dm_w_a[i] = 1'b0;
         size_a[i] = 2'd0; sign_a[i] = 1'b0; addr_a[i] = 32'h0; wdata_a[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst.rdata", rdata_a[0], 32'h0);
      check("rst.ready", {31'h0, ready_a[0]}, 32'h0);
      check("rst.err", {31'h0, err_a[0]}, 32'h0);
      #2;
      for (int i = 0; i < NI; i++) rst_a[i] = 1'b1;
      @(posedge clk); #1;

      // Word write/read, WAIT=1
      op("sw10", 0, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 3, 32'h0, 0);
      op("lw10", 0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0, 3, 32'hDEADBEEF, 0);
      check("hold.rdata", rdata_a[0], 32'hDEADBEEF);

      // Byte store merge and half loads from the merged word
      op("sw10b", 0, 0, 1, 2'd2, 0, 32'h10, 32'h11223344, 0, 3, 32'h0, 0);
      op("sb12", 0, 0, 1, 2'd0, 0, 32'h12, 32'hFFFFFFAA, 0, 3, 32'h0, 0);
      op("lw10m", 0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0, 3, 32'h11AA3344, 0);
      op("lh12", 0, 1, 0, 2'd1, 1, 32'h12, 32'h0, 0, 3, 32'h000011AA, 0);
      op("sh10", 0, 0, 1, 2'd1, 0, 32'h10, 32'h00008001, 0, 3, 32'h0, 0);
      op("lw10h", 0, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0, 3, 32'h11AA8001, 0);

      // Extension on 0x0000FF80
      op("sw20", 0, 0, 1, 2'd2, 0, 32'h20, 32'h0000FF80, 0, 3, 32'h0, 0);
      op("lb20", 0, 1, 0, 2'd0, 1, 32'h20, 32'h0, 0, 3, 32'hFFFFFF80, 0);
      op("lbu20", 0, 1, 0, 2'd0, 0, 32'h20, 32'h0, 0, 3, 32'h00000080, 0);
      op("lh20", 0, 1, 0, 2'd1, 1, 32'h20, 32'h0, 0, 3, 32'hFFFFFF80, 0);
      op("lhu20", 0, 1, 0, 2'd1, 0, 32'h20, 32'h0, 0, 3, 32'h0000FF80, 0);
      op("lb21", 0, 1, 0, 2'd0, 1, 32'h21, 32'h0, 0, 3, 32'hFFFFFFFF, 0);
      op("lhu22", 0, 1, 0, 2'd1, 0, 32'h22, 32'h0, 0, 3, 32'h0, 0);

      // Errors: ready/err in cycle 1, rdata 0, memory unchanged
      op("sw00", 0, 0, 1, 2'd2, 0, 32'h0, 32'hCAFE0001, 0, 3, 32'h0, 0);
      op("lw20", 0, 1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 3, 32'h0000FF80, 0);
      op("e.lw22", 0, 1, 0, 2'd2, 0, 32'h22, 32'h0, 0, 1, 32'h0, 1);
      op("e.lh21", 0, 1, 0, 2'd1, 1, 32'h21, 32'h0, 0, 1, 32'h0, 1);
      op("e.sz3", 0, 0, 1, 2'd3, 0, 32'h20, 32'h12345678, 0, 1, 32'h0, 1);
      op("e.rw", 0, 1, 1, 2'd2, 0, 32'h20, 32'h12345678, 0, 1, 32'h0, 1);
      op("e.range", 0, 0, 1, 2'd2, 0, 32'h100, 32'h87654321, 0, 1, 32'h0, 1);
      op("e.sh23", 0, 0, 1, 2'd1, 0, 32'h23, 32'h0000BBBB, 0, 1, 32'h0, 1);
      op("lw20u", 0, 1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 3, 32'h0000FF80, 0);
      op("lw00u", 0, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0, 3, 32'hCAFE0001, 0);

      // Latency sweep; cs held through BUSY on the longer ones
      op("w0.sw", 1, 0, 1, 2'd2, 0, 32'h8, 32'hA5A5A5A5, 0, 2, 32'h0, 0);
      op("w0.lw", 1, 1, 0, 2'd2, 0, 32'h8, 32'h0, 0, 2, 32'hA5A5A5A5, 0);
      op("w3.sw", 2, 0, 1, 2'd2, 0, 32'h8, 32'h01020304, 1, 5, 32'h0, 0);
      op("w3.lw", 2, 1, 0, 2'd2, 0, 32'h8, 32'h0, 1, 5, 32'h01020304, 0);
      op("w15.sw", 3, 0, 1, 2'd2, 0, 32'hFC, 32'h0BADF00D, 1, 17, 32'h0, 0);
      op("w15.lb", 3, 1, 0, 2'd0, 0, 32'hFF, 32'h0, 1, 17, 32'h0000000B, 0);

      // Reset mid-operation, WAIT=4
      op("w4.sw1", 4, 0, 1, 2'd2, 0, 32'h0, 32'h00000001, 0, 6, 32'h0, 0);
      op("w4.lw", 4, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0, 6, 32'h00000001, 0);
      cs_a[4] = 1'b1; dm_w_a[4] = 1'b1; size_a[4] = 2'd2; addr_a[4] = 32'h0; wdata_a[4] = 32'h55;
      @(posedge clk); #1;
      cs_a[4] = 1'b0; dm_w_a[4] = 1'b0;
      @(posedge clk); #1;
      rst_a[4] = 1'b0;
      #1;
      $display("txn %-10s inst=4 rst pulse in cycle 2 rdata=0x%08h ready=%0b err=%0b",
               "w4.rst", rdata_a[4], ready_a[4], err_a[4]);
      check("w4.rst.rdata", rdata_a[4], 32'h0);
      check("w4.rst.ready", {31'h0, ready_a[4]}, 32'h0);
      check("w4.rst.err", {31'h0, err_a[4]}, 32'h0);
      #2;
      rst_a[4] = 1'b1;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (ready_a[4]) pulses++;
      end
      check("w4.nopulse", 32'(pulses), 32'h0);
      op("w4.lw2", 4, 1, 0, 2'd2, 0, 32'h0, 32'h0, 0, 6, 32'h00000001, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
